// File: rtl/bht_tagged_sat_pkg.sv
// Shared types for the tagged branch history table: update/prediction records
// exchanged with the frontend and the clear-sweep state encoding.
package bht_tagged_sat_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned INSTR_PER_FETCH = 2;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef enum logic {
        BHT_IDLE,
        BHT_CLEAR
    } bht_ctr_state_e;

endpackage

// File: rtl/bht_tagged_array.sv
// Entry storage for the branch history table, one memory per column so every
// prediction slot has its own read port. No reset; a row clear beats a write.
module bht_tagged_array #(
    parameter int unsigned ROWS     = 512,
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned ENTRY_W  = 11,
    parameter int unsigned ROW_W    = 9,
    parameter int unsigned COL_IW   = 1
) (
    input  logic                               clk,
    input  logic [ROW_W-1:0]                   pred_row,
    output logic [NR_PORTS-1:0][ENTRY_W-1:0]   pred_entries,
    input  logic [ROW_W-1:0]                   upd_row,
    input  logic [COL_IW-1:0]                  upd_col,
    output logic [ENTRY_W-1:0]                 upd_entry,
    input  logic                               wr_en,
    input  logic [ROW_W-1:0]                   wr_row,
    input  logic [COL_IW-1:0]                  wr_col,
    input  logic [ENTRY_W-1:0]                 wr_entry,
    input  logic                               clr_en,
    input  logic [ROW_W-1:0]                   clr_row
);

    logic [NR_PORTS-1:0][ENTRY_W-1:0] upd_by_col;

    for (genvar c = 0; c < NR_PORTS; c++) begin : g_col
        logic [ENTRY_W-1:0] col_mem [ROWS];

        always_ff @(posedge clk) begin
            if (clr_en) begin
                col_mem[clr_row] <= '0;
            end else if (wr_en && (wr_col == COL_IW'(c))) begin
                col_mem[wr_row] <= wr_entry;
            end
        end

        assign pred_entries[c] = col_mem[pred_row];
        assign upd_by_col[c]   = col_mem[upd_row];
    end

    assign upd_entry = upd_by_col[upd_col];

endmodule

// File: rtl/bht_tagged_sat.sv
// Tagged branch history table with saturating counters: combinational
// per-slot prediction, registered read-modify-write training, row-sweep clear.
//
//   state     | meaning
//   BHT_CLEAR | sweeping rows, one per cycle; predictions and training blocked
//   BHT_IDLE  | table valid; predictions served, stage writes allowed
module bht_tagged_sat
    import bht_tagged_sat_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned NR_PORTS   = INSTR_PER_FETCH,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            debug_mode_i,
    input  logic [VLEN-1:0]                 vpc_i,
    input  bht_update_t                     bht_update_i,
    output bht_prediction_t [NR_PORTS-1:0]  bht_prediction_o,
    output logic                            busy_o
);

    localparam int unsigned OFFSET  = 1;
    localparam int unsigned COL_W   = $clog2(NR_PORTS);
    localparam int unsigned COL_IW  = (COL_W == 0) ? 1 : COL_W;
    localparam int unsigned ROWS    = NR_ENTRIES / NR_PORTS;
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned ROW_LO  = COL_W + OFFSET;
    localparam int unsigned TAG_LO  = ROW_LO + ROW_W;
    localparam int unsigned ENTRY_W = 1 + TAG_BITS + CTR_BITS;

    localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_WT - CTR_BITS'(1);

    function automatic logic [ROW_W-1:0] row_of(input logic [VLEN-1:0] pc);
        return ROW_W'(pc >> ROW_LO);
    endfunction

    function automatic logic [COL_IW-1:0] col_of(input logic [VLEN-1:0] pc);
        return (COL_W == 0) ? '0 : COL_IW'(pc >> OFFSET);
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [VLEN-1:0] pc);
        return TAG_BITS'(pc >> TAG_LO);
    endfunction

    bht_ctr_state_e      state_q, state_d;
    logic [ROW_W-1:0]    clr_cnt_q, clr_cnt_d;

    logic                stage_valid;
    logic                stage_taken;
    logic [ROW_W-1:0]    stage_row;
    logic [COL_IW-1:0]   stage_col;
    logic [TAG_BITS-1:0] stage_tag;
    logic                capture;

    logic [NR_PORTS-1:0][ENTRY_W-1:0] pred_rows;
    logic [ENTRY_W-1:0]  upd_entry;
    logic [CTR_BITS-1:0] upd_ctr, new_ctr;
    logic                upd_hit;
    logic                wr_en;
    logic [TAG_BITS-1:0] vpc_tag;
    logic                unused_pred_bits;

    assign busy_o  = (state_q == BHT_CLEAR);
    assign capture = bht_update_i.valid && !debug_mode_i && !busy_o && !flush_i;
    // A flush kills the pending stage write on the same edge it restarts the sweep.
    assign wr_en   = stage_valid && !busy_o && !flush_i;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            BHT_CLEAR: begin
                if (flush_i) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == LAST_ROW) begin
                    state_d   = BHT_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ROW_W'(1);
                end
            end
            BHT_IDLE: begin
                if (flush_i) begin
                    state_d   = BHT_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = BHT_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= BHT_CLEAR;
            clr_cnt_q   <= '0;
            stage_valid <= 1'b0;
            stage_taken <= 1'b0;
            stage_row   <= '0;
            stage_col   <= '0;
            stage_tag   <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            stage_valid <= capture;
            if (capture) begin
                stage_taken <= bht_update_i.taken;
                stage_row   <= row_of(bht_update_i.pc);
                stage_col   <= col_of(bht_update_i.pc);
                stage_tag   <= tag_of(bht_update_i.pc);
            end
        end
    end

    assign upd_ctr = upd_entry[CTR_BITS-1:0];
    assign upd_hit = upd_entry[ENTRY_W-1] && (upd_entry[CTR_BITS +: TAG_BITS] == stage_tag);

    always_comb begin
        new_ctr = stage_taken ? CTR_WT : CTR_WNT;
        if (upd_hit) begin
            new_ctr = upd_ctr;
            if (stage_taken && (upd_ctr != CTR_MAX)) begin
                new_ctr = upd_ctr + CTR_BITS'(1);
            end else if (!stage_taken && (upd_ctr != '0)) begin
                new_ctr = upd_ctr - CTR_BITS'(1);
            end
        end
    end

    bht_tagged_array #(
        .ROWS     (ROWS),
        .NR_PORTS (NR_PORTS),
        .ENTRY_W  (ENTRY_W),
        .ROW_W    (ROW_W),
        .COL_IW   (COL_IW)
    ) u_array (
        .clk          (clk_i),
        .pred_row     (row_of(vpc_i)),
        .pred_entries (pred_rows),
        .upd_row      (stage_row),
        .upd_col      (stage_col),
        .upd_entry    (upd_entry),
        .wr_en        (wr_en),
        .wr_row       (stage_row),
        .wr_col       (stage_col),
        .wr_entry     ({1'b1, stage_tag, new_ctr}),
        .clr_en       (busy_o),
        .clr_row      (clr_cnt_q)
    );

    assign vpc_tag = tag_of(vpc_i);

    for (genvar i = 0; i < NR_PORTS; i++) begin : g_pred
        logic hit;
        assign hit = pred_rows[i][ENTRY_W-1] &&
                     (pred_rows[i][CTR_BITS +: TAG_BITS] == vpc_tag) && !busy_o;
        assign bht_prediction_o[i].valid = hit;
        assign bht_prediction_o[i].taken = hit && pred_rows[i][CTR_BITS-1];
    end

    // Only the counter MSB matters for a prediction.
    assign unused_pred_bits = ^pred_rows;

endmodule
